// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite signal bundle between the bridge's AHB master and the SRAM responder.
interface ahb_sram_slave_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [63:0]           hwdata;
  logic                  hready;
  logic                  hreadyout;
  logic [1:0]            hresp;
  logic [63:0]           hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB responder backed by a 64-bit SRAM: single transfers, fixed wait states,
// byte-lane writes, two-cycle ERROR for misaligned or out-of-window accesses.
module ahb_sram_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH       = 512,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 0
) (
  input  logic            hclk,
  input  logic            hreset,
  ahb_sram_slave_if.slave bus
);

  localparam int              IDX_W     = $clog2(DEPTH);
  localparam int              AW1       = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0]  LIMIT     = AW1'(BASE_ADDR) + AW1'(DEPTH * 8);
  localparam logic [3:0]      WAIT_INIT = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
  localparam logic [1:0]      RESP_OKAY = 2'b00;
  localparam logic [1:0]      RESP_ERR  = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  function automatic logic is_aligned(input logic [2:0] size, input logic [2:0] lsb);
    case (size)
      3'd0:    return 1'b1;
      3'd1:    return lsb[0] == 1'b0;
      3'd2:    return lsb[1:0] == 2'b00;
      3'd3:    return lsb == 3'b000;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] lsb);
    logic [7:0] base;
    case (size)
      3'd0:    base = 8'h01;
      3'd1:    base = 8'h03;
      3'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lsb;
  endfunction

  function automatic logic [63:0] merge_lanes(input logic [63:0] old_word,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  lanes);
    logic [63:0] merged;
    for (int i = 0; i < 8; i++)
      merged[8*i +: 8] = lanes[i] ? wdata[8*i +: 8] : old_word[8*i +: 8];
    return merged;
  endfunction

  logic [63:0]           mem [DEPTH];
  state_t                state;
  logic                  ready_r;
  logic [1:0]            resp_r;
  logic [63:0]           rdata_r;
  logic [3:0]            cnt;
  logic                  vld_p1;
  logic                  write_p1;
  logic [IDX_W-1:0]      idx_p1;
  logic [7:0]            lanes_p1;

  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_range;
  logic                  accept;
  logic                  acc_legal;
  logic [IDX_W-1:0]      acc_idx;
  logic [7:0]            acc_lanes;
  logic                  commit;
  logic [IDX_W-1:0]      rd_idx;
  logic [63:0]           rd_word;
  logic                  unused_ok;

  // Address phase p0: decode and legality of the transfer on the bus.
  assign offset    = bus.haddr - BASE_ADDR;
  assign in_range  = ({1'b0, bus.haddr} >= AW1'(BASE_ADDR)) && ({1'b0, bus.haddr} < LIMIT);
  assign accept    = bus.hsel && bus.hready && bus.htrans[1] && ready_r;
  assign acc_legal = (bus.hsize <= 3'd3) && is_aligned(bus.hsize, bus.haddr[2:0]) && in_range;
  assign acc_idx   = offset[IDX_W+2:3];
  assign acc_lanes = lane_mask(bus.hsize, bus.haddr[2:0]);
  assign unused_ok = ^{bus.hburst, bus.htrans[0], offset};

  // Data phase p1: a pending write lands when this slave signals ready.
  assign commit  = vld_p1 && write_p1 && ready_r;
  assign rd_idx  = (state == S_WAIT) ? idx_p1 : acc_idx;
  assign rd_word = (commit && (idx_p1 == rd_idx))
                   ? merge_lanes(mem[rd_idx], bus.hwdata, lanes_p1) : mem[rd_idx];

  always_ff @(posedge hclk) begin
    if (commit && !hreset)
      for (int i = 0; i < 8; i++)
        if (lanes_p1[i]) mem[idx_p1][8*i +: 8] <= bus.hwdata[8*i +: 8];
  end

  always_ff @(posedge hclk) begin
    if (accept) begin
      write_p1 <= bus.hwrite;
      idx_p1   <= acc_idx;
      lanes_p1 <= acc_lanes;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state   <= S_IDLE;
      ready_r <= 1'b1;
      resp_r  <= RESP_OKAY;
      rdata_r <= '0;
      cnt     <= '0;
      vld_p1  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ERR2: begin
          vld_p1 <= accept && acc_legal;
          if (accept && !acc_legal) begin
            state   <= S_ERR1;
            ready_r <= 1'b0;
            resp_r  <= RESP_ERR;
          end else if (accept && (WAIT_CYCLES > 0)) begin
            state   <= S_WAIT;
            cnt     <= WAIT_INIT;
            ready_r <= 1'b0;
            resp_r  <= RESP_OKAY;
          end else begin
            state   <= S_IDLE;
            ready_r <= 1'b1;
            resp_r  <= RESP_OKAY;
            if (accept && !bus.hwrite) rdata_r <= rd_word;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state   <= S_IDLE;
            ready_r <= 1'b1;
            if (!write_p1) rdata_r <= rd_word;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ERR1: begin
          state   <= S_ERR2;
          ready_r <= 1'b1;
          resp_r  <= RESP_ERR;
        end
        default: begin
          state   <= S_IDLE;
          ready_r <= 1'b1;
          resp_r  <= RESP_OKAY;
        end
      endcase
    end
  end

  assign bus.hreadyout = ready_r;
  assign bus.hresp     = resp_r;
  assign bus.hrdata    = rdata_r;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: three instances with 0, 3 and 2 wait states.
module tb_ahb_sram_slave;

  logic        hclk = 1'b0;
  logic        rst;
  logic        rst1;
  int          sel;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [63:0] hwdata;
  logic        hold_low;
  logic        bus_ready;
  logic        cur_ready;
  logic [1:0]  cur_resp;
  logic [63:0] cur_rdata;
  int          checks = 0;
  int          errors = 0;
  int          n;

  always #5 hclk = ~hclk;

  ahb_sram_slave_if #(.ADDR_WIDTH(32)) if0 ();
  ahb_sram_slave_if #(.ADDR_WIDTH(32)) if1 ();
  ahb_sram_slave_if #(.ADDR_WIDTH(32)) if2 ();

  assign {if0.haddr, if0.htrans, if0.hwrite, if0.hsize, if0.hburst, if0.hwdata} = {haddr, htrans, hwrite, hsize, 3'b000, hwdata};
  assign {if1.haddr, if1.htrans, if1.hwrite, if1.hsize, if1.hburst, if1.hwdata} = {haddr, htrans, hwrite, hsize, 3'b000, hwdata};
  assign {if2.haddr, if2.htrans, if2.hwrite, if2.hsize, if2.hburst, if2.hwdata} = {haddr, htrans, hwrite, hsize, 3'b000, hwdata};
  assign if0.hsel = hsel && (sel == 0);
  assign if1.hsel = hsel && (sel == 1);
  assign if2.hsel = hsel && (sel == 2);
  assign bus_ready  = if0.hreadyout & if1.hreadyout & if2.hreadyout & !hold_low;
  assign if0.hready = bus_ready;
  assign if1.hready = bus_ready;
  assign if2.hready = bus_ready;

  always_comb begin
    cur_ready = if0.hreadyout;
    cur_resp  = if0.hresp;
    cur_rdata = if0.hrdata;
    if (sel == 1) begin
      cur_ready = if1.hreadyout; cur_resp = if1.hresp; cur_rdata = if1.hrdata;
    end else if (sel == 2) begin
      cur_ready = if2.hreadyout; cur_resp = if2.hresp; cur_rdata = if2.hrdata;
    end
  end

  ahb_sram_slave #(.WAIT_CYCLES(0)) u_w0 (.hclk(hclk), .hreset(rst),        .bus(if0));
  ahb_sram_slave #(.WAIT_CYCLES(3)) u_w3 (.hclk(hclk), .hreset(rst | rst1), .bus(if1));
  ahb_sram_slave #(.WAIT_CYCLES(2)) u_w2 (.hclk(hclk), .hreset(rst),        .bus(if2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz);
    hsel = 1'b1; haddr = a; htrans = 2'b10; hwrite = wr; hsize = sz;
  endtask

  task automatic idle_bus();
    hsel = 1'b0; htrans = 2'b00;
  endtask

  task automatic wait_ready(input int limit, output int lows);
    lows = 0;
    while (!cur_ready && lows < limit) begin
      tick();
      lows++;
    end
    if (!cur_ready) check("ready_timeout", 64'(cur_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1; rst1 = 1'b0; sel = 0; hold_low = 1'b0;
    hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; hwdata = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", 64'(cur_ready), 64'd1);
    check("rst_resp",  64'(cur_resp),  64'd0);
    check("rst_rdata", cur_rdata,      64'd0);

    // Zero-wait write followed immediately by a read of the same word.
    addr_phase(32'h10, 1'b1, 3'd3); tick();
    check("wr_ready", 64'(cur_ready), 64'd1);
    hwdata = 64'h1122334455667788;
    addr_phase(32'h10, 1'b0, 3'd3); tick();
    check("b2b_ready", 64'(cur_ready), 64'd1);
    check("b2b_resp",  64'(cur_resp),  64'd0);
    check("b2b_rdata", cur_rdata, 64'h1122334455667788);
    idle_bus(); tick();

    addr_phase(32'h13, 1'b1, 3'd0); tick();
    hwdata = 64'hAAAAAAAAAAAAAAAA; idle_bus(); tick();
    addr_phase(32'h10, 1'b0, 3'd3); tick(); idle_bus();
    check("byte_lane", cur_rdata, 64'h11223344AA667788);
    tick();

    addr_phase(32'h16, 1'b1, 3'd1); tick();
    hwdata = 64'hBEEFBEEFBEEFBEEF;
    addr_phase(32'h10, 0, 3'd3); tick(); idle_bus();
    check("half_bypass", cur_rdata, 64'hBEEF3344AA667788);
    tick();

    // Misaligned word read, then the first address past the window.
    addr_phase(32'h12, 1'b0, 3'd2); tick(); idle_bus();
    check("mis_err1_ready", 64'(cur_ready), 64'd0);
    check("mis_err1_resp",  64'(cur_resp),  64'd1);
    tick();
    check("mis_err2_ready", 64'(cur_ready), 64'd1);
    check("mis_err2_resp",  64'(cur_resp),  64'd1);
    check("mis_rdata_hold", cur_rdata, 64'hBEEF3344AA667788);
    tick();
    check("mis_after_resp", 64'(cur_resp), 64'd0);

    addr_phase(32'h1000, 1'b1, 3'd3); tick(); idle_bus();
    hwdata = 64'hFFFFFFFFFFFFFFFF;
    check("oob_err1_ready", 64'(cur_ready), 64'd0);
    check("oob_err1_resp",  64'(cur_resp),  64'd1);
    tick();
    check("oob_err2_ready", 64'(cur_ready), 64'd1);
    check("oob_err2_resp",  64'(cur_resp),  64'd1);
    tick();
    addr_phase(32'h1010, 1'b1, 3'd3); tick(); idle_bus();
    check("alias_err1_resp", 64'(cur_resp), 64'd1);
    tick(); tick();

    // BUSY with select, and NONSEQ while another slave stalls the bus.
    hsel = 1'b1; haddr = 32'h10; htrans = 2'b01; hwrite = 1'b1; hsize = 3'd3; tick();
    check("busy_ready", 64'(cur_ready), 64'd1);
    check("busy_resp",  64'(cur_resp),  64'd0);
    idle_bus(); hwdata = 64'h0; tick();
    hold_low = 1'b1;
    addr_phase(32'h10, 1'b1, 3'd3); tick();
    check("stall_ready", 64'(cur_ready), 64'd1);
    hold_low = 1'b0; idle_bus(); hwdata = 64'h0; tick();
    addr_phase(32'h10, 1'b0, 3'd3); tick(); idle_bus();
    check("mem_unchanged", cur_rdata, 64'hBEEF3344AA667788);
    tick();

    // Two wait states per OKAY data phase.
    sel = 2;
    addr_phase(32'h20, 1'b1, 3'd3); tick(); idle_bus();
    hwdata = 64'hCAFEF00D12345678;
    wait_ready(10, n);
    check("w2_wr_lows", 64'(n), 64'd2);
    tick();
    addr_phase(32'h20, 1'b0, 3'd3); tick(); idle_bus();
    check("w2_rd_first", 64'(cur_ready), 64'd0);
    wait_ready(10, n);
    check("w2_rd_lows", 64'(n), 64'd2);
    check("w2_rdata", cur_rdata, 64'hCAFEF00D12345678);
    tick();

    // Reset in the middle of a three-wait write drops the write.
    sel = 1;
    addr_phase(32'h20, 1'b1, 3'd3); tick(); idle_bus();
    hwdata = 64'h0123456789ABCDEF;
    wait_ready(10, n);
    check("w3_wr_lows", 64'(n), 64'd3);
    tick();
    addr_phase(32'h20, 1'b1, 3'd3); tick(); idle_bus();
    hwdata = 64'hDEADDEADDEADDEAD;
    tick();
    rst1 = 1'b1; tick(); rst1 = 1'b0;
    check("rst_mid_ready", 64'(cur_ready), 64'd1);
    check("rst_mid_resp",  64'(cur_resp),  64'd0);
    check("rst_mid_rdata", cur_rdata, 64'd0);
    addr_phase(32'h20, 1'b0, 3'd3); tick(); idle_bus();
    wait_ready(10, n);
    check("w3_rd_lows", 64'(n), 64'd3);
    check("w3_no_commit", cur_rdata, 64'h0123456789ABCDEF);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
